mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, inputs, 1 bit each: EX/MEM instruction valid and its control bits.
REQ-004 SHALL have port ex_rd, input, 3 bits: destination register of the EX/MEM instruction.
REQ-005 SHALL have ports ex_alu_out and ex_store_data, inputs, 16 bits each: effective address or ALU result, and store data.
REQ-006 SHALL have ports stall and flush, inputs, 1 bit each: hold the M stage; kill the instruction entering M.
REQ-007 SHALL have ports dwe (1 bit), addr (8 bits) and wdata (16 bits), outputs: data memory write enable, address and write data.
REQ-008 SHALL have port rdata, input, 16 bits: data memory read data, valid one cycle after addr is presented.
REQ-009 SHALL have ports wb_valid, wb_reg_write (1 bit each), wb_rd (3 bits) and wb_data (16 bits), outputs: writeback bundle.
REQ-010 SHALL have ports m_load (1 bit), m_rd (3 bits), m_fwd_valid (1 bit) and m_fwd_data (16 bits), outputs: hazard and forwarding info from the M stage.
REQ-011 SHALL have port mem_fault, output, 1 bit: sticky address-range fault flag.

Function
REQ-012 SHALL hold an M register (valid, read, write, reg_write, rd, alu_out, store_data) and a W register (valid, load, reg_write, rd, alu_out).
REQ-013 SHALL capture the EX inputs into M at a rising edge when stall=0 and flush=0.
REQ-014 SHALL load M with a bubble (valid=0, other fields unchanged) when stall=0 and flush=1.
REQ-015 SHALL hold M unchanged when stall=1; flush SHALL be ignored in that cycle.
REQ-016 SHALL drive addr combinationally as M.alu_out[7:0], and drive wdata as M.store_data.
REQ-017 SHALL drive dwe = M.valid & M.write & ~stall (& ~range fault when enabled).
REQ-018 SHALL advance M into W at each rising edge when stall=0, and load a bubble into W (w_valid=0) when stall=1.
REQ-019 SHALL drive wb_data = rdata when W.load=1, otherwise W.alu_out, giving a load result latency of 2 edges from M capture.
REQ-020 SHALL drive wb_valid = W.valid and wb_reg_write = W.valid & W.reg_write.
REQ-021 SHALL keep addr stable and dwe=0 during stall, so that rdata re-reads the same location and stays stable.
REQ-022 SHALL drive m_load = M.valid & M.read and m_rd = M.rd.
REQ-023 SHALL drive m_fwd_valid = M.valid & M.reg_write & ~M.read, with m_fwd_data = M.alu_out.
REQ-024 SHALL make a load in the cycle after a store to the same address return the stored value.
REQ-025 SHALL treat an instruction with both read and write set as a store whose W.load = 0.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, clear M.valid, W.valid and mem_fault, and zero M.alu_out, M.store_data and W.alu_out.
REQ-027 SHALL therefore present after reset: dwe=0, addr=0, wdata=0, wb_valid=0, wb_reg_write=0, m_load=0, m_fwd_valid=0.
REQ-028 SHALL give rst priority over stall and flush.
REQ-029 SHALL discard any in-flight instruction when rst is asserted mid-operation, with no store issued in the reset cycle.

Configuration
REQ-030 SHALL implement the address range check when macro MEM_ADDR_CHECK_EN is defined: a valid read or write with M.alu_out[15:8] != 0 suppresses dwe and sets mem_fault, which stays set until reset.
REQ-031 SHALL, when MEM_ADDR_CHECK_EN is defined, return 16'h0000 on wb_data for a faulting load.
REQ-032 SHALL, without MEM_ADDR_CHECK_EN, ignore alu_out[15:8] and tie mem_fault to 0.

Verification
REQ-033 SHALL cover: store alu_out=16'h0005, store_data=16'h1234, then load addr 5 next cycle -> dwe=1 for one cycle; load wb_data=16'h1234 two edges after the load is captured.
REQ-034 SHALL cover: ALU op rd=3, alu_out=16'h00AA -> m_fwd_valid=1 with m_fwd_data=16'h00AA, then wb_rd=3, wb_data=16'h00AA.
REQ-035 SHALL cover: load into M with stall held 2 cycles -> addr constant, dwe=0, wb_valid=0 for 2 cycles, then a single wb_valid pulse with correct data.
REQ-036 SHALL cover: store presented with flush=1 -> no dwe pulse, memory unchanged, wb_valid stays 0.
REQ-037 SHALL cover: rst=1 while a store sits in M -> dwe=0 in that cycle, all outputs at reset values on the next edge.
REQ-038 SHALL cover, with MEM_ADDR_CHECK_EN: store to alu_out=16'h0105 -> dwe=0, mem_fault=1 and stays 1 until rst.

Source files
------------

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline memory stage. It holds an M register that drives the
//            data-memory port and hazard/forwarding info. It also holds a W
//            register that builds the writeback bundle one cycle later.
// Option   : MEM_ADDR_CHECK_EN - when defined, an access with a non-zero
//            alu_out[15:8] is treated as out of range. Such a store is
//            suppressed, a faulting load returns zero, and the sticky
//            mem_fault flag is raised.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic [2:0]  ex_rd,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_store_data,
  input  logic        stall,
  input  logic        flush,
  output logic        dwe,
  output logic [7:0]  addr,
  output logic [15:0] wdata,
  input  logic [15:0] rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        m_load,
  output logic [2:0]  m_rd,
  output logic        m_fwd_valid,
  output logic [15:0] m_fwd_data,
  output logic        mem_fault
);

  // M register
  logic        m_valid_q, m_valid_d;
  logic        m_read_q, m_read_d;
  logic        m_write_q, m_write_d;
  logic        m_reg_write_q, m_reg_write_d;
  logic [2:0]  m_rd_q, m_rd_d;
  logic [15:0] m_alu_out_q, m_alu_out_d;
  logic [15:0] m_store_data_q, m_store_data_d;

  // W register
  logic        w_valid_q, w_valid_d;
  logic        w_load_q, w_load_d;
  logic        w_reg_write_q, w_reg_write_d;
  logic [2:0]  w_rd_q, w_rd_d;
  logic [15:0] w_alu_out_q, w_alu_out_d;

  logic        range_err;

`ifdef MEM_ADDR_CHECK_EN
  logic        fault_q, fault_d;
  logic        w_fault_q, w_fault_d;

  // Out-of-range access: any valid memory op whose upper address byte is set
  assign range_err = m_valid_q & (m_read_q | m_write_q) & (|m_alu_out_q[15:8]);
`else
  assign range_err = 1'b0;
`endif

  // Next-state for M and W: stall freezes M and bubbles W; flush bubbles M
  always_comb begin
    m_valid_d      = m_valid_q;
    m_read_d       = m_read_q;
    m_write_d      = m_write_q;
    m_reg_write_d  = m_reg_write_q;
    m_rd_d         = m_rd_q;
    m_alu_out_d    = m_alu_out_q;
    m_store_data_d = m_store_data_q;
    w_valid_d      = 1'b0;
    w_load_d       = w_load_q;
    w_reg_write_d  = w_reg_write_q;
    w_rd_d         = w_rd_q;
    w_alu_out_d    = w_alu_out_q;
`ifdef MEM_ADDR_CHECK_EN
    fault_d        = fault_q | range_err;
    w_fault_d      = w_fault_q;
`endif
    if (!stall) begin
      if (flush) begin
        m_valid_d      = 1'b0;
      end else begin
        m_valid_d      = ex_valid;
        m_read_d       = ex_mem_read;
        m_write_d      = ex_mem_write;
        m_reg_write_d  = ex_reg_write;
        m_rd_d         = ex_rd;
        m_alu_out_d    = ex_alu_out;
        m_store_data_d = ex_store_data;
      end
      w_valid_d      = m_valid_q;
      // A combined read+write is a store, so it never selects rdata
      w_load_d       = m_read_q & ~m_write_q;
      w_reg_write_d  = m_reg_write_q;
      w_rd_d         = m_rd_q;
      w_alu_out_d    = m_alu_out_q;
`ifdef MEM_ADDR_CHECK_EN
      w_fault_d      = range_err;
`endif
    end
  end

  // Pipeline registers with synchronous reset taking priority over stall/flush
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q      <= 1'b0;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_reg_write_q  <= 1'b0;
      m_rd_q         <= 3'd0;
      m_alu_out_q    <= 16'h0000;
      m_store_data_q <= 16'h0000;
      w_valid_q      <= 1'b0;
      w_load_q       <= 1'b0;
      w_reg_write_q  <= 1'b0;
      w_rd_q         <= 3'd0;
      w_alu_out_q    <= 16'h0000;
`ifdef MEM_ADDR_CHECK_EN
      fault_q        <= 1'b0;
      w_fault_q      <= 1'b0;
`endif
    end else begin
      m_valid_q      <= m_valid_d;
      m_read_q       <= m_read_d;
      m_write_q      <= m_write_d;
      m_reg_write_q  <= m_reg_write_d;
      m_rd_q         <= m_rd_d;
      m_alu_out_q    <= m_alu_out_d;
      m_store_data_q <= m_store_data_d;
      w_valid_q      <= w_valid_d;
      w_load_q       <= w_load_d;
      w_reg_write_q  <= w_reg_write_d;
      w_rd_q         <= w_rd_d;
      w_alu_out_q    <= w_alu_out_d;
`ifdef MEM_ADDR_CHECK_EN
      fault_q        <= fault_d;
      w_fault_q      <= w_fault_d;
`endif
    end
  end

  // Memory port: the write is blocked while stalled or in reset so that a
  // held or discarded store never commits
  assign addr  = m_alu_out_q[7:0];
  assign wdata = m_store_data_q;
  assign dwe   = m_valid_q & m_write_q & ~stall & ~rst & ~range_err;

  // Hazard and forwarding info from M; loads cannot forward until W
  assign m_load      = m_valid_q & m_read_q;
  assign m_rd        = m_rd_q;
  assign m_fwd_valid = m_valid_q & m_reg_write_q & ~m_read_q;
  assign m_fwd_data  = m_alu_out_q;

  // Writeback bundle
  assign wb_valid     = w_valid_q;
  assign wb_reg_write = w_valid_q & w_reg_write_q;
  assign wb_rd        = w_rd_q;

`ifdef MEM_ADDR_CHECK_EN
  assign wb_data   = w_fault_q ? 16'h0000 : (w_load_q ? rdata : w_alu_out_q);
  assign mem_fault = fault_q;
`else
  assign wb_data   = w_load_q ? rdata : w_alu_out_q;
  assign mem_fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage with a synchronous
//            256x16 data memory model (read data one cycle after address).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0]  ex_rd;
  logic [15:0] ex_alu_out, ex_store_data;
  logic        stall, flush;
  logic        dwe;
  logic [7:0]  addr;
  logic [15:0] wdata, rdata;
  logic        wb_valid, wb_reg_write;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        m_load, m_fwd_valid;
  logic [2:0]  m_rd;
  logic [15:0] m_fwd_data;
  logic        mem_fault;
  logic        mem_clr;

  logic [15:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .stall(stall), .flush(flush),
    .dwe(dwe), .addr(addr), .wdata(wdata), .rdata(rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .m_load(m_load), .m_rd(m_rd), .m_fwd_valid(m_fwd_valid), .m_fwd_data(m_fwd_data),
    .mem_fault(mem_fault)
  );

  // Synchronous data memory: registered read, old data on a same-cycle write
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      rdata <= 16'h0000;
    end else begin
      if (dwe) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rd_en, input logic wr_en,
                        input logic rw, input logic [2:0] rd,
                        input logic [15:0] alu, input logic [15:0] sd);
    ex_valid = v; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_reg_write = rw;
    ex_rd = rd; ex_alu_out = alu; ex_store_data = sd;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1; stall = 1'b0; flush = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    tick(); tick();
    mem_clr = 1'b0; rst = 1'b0;
    #1;
    checks++; if (dwe !== 1'b0) begin errors++; $display("FAIL rst_dwe got %0h want 0", dwe); end
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %0h want 0", addr); end
    checks++; if (wdata !== 16'h0000) begin errors++; $display("FAIL rst_wdata got %0h want 0", wdata); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %0h want 0", wb_valid); end
    checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL rst_wb_reg_write got %0h want 0", wb_reg_write); end
    checks++; if (m_load !== 1'b0) begin errors++; $display("FAIL rst_m_load got %0h want 0", m_load); end
    checks++; if (m_fwd_valid !== 1'b0) begin errors++; $display("FAIL rst_m_fwd_valid got %0h want 0", m_fwd_valid); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL rst_mem_fault got %0h want 0", mem_fault); end
  endtask

  task automatic test_store_load();
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0005, 16'h1234);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0005, 16'h0000);
    #1;
    checks++; if (dwe !== 1'b1) begin errors++; $display("FAIL sl_dwe got %0h want 1", dwe); end
    checks++; if (addr !== 8'h05) begin errors++; $display("FAIL sl_addr got %0h want 05", addr); end
    checks++; if (wdata !== 16'h1234) begin errors++; $display("FAIL sl_wdata got %0h want 1234", wdata); end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    #1;
    checks++; if (dwe !== 1'b0) begin errors++; $display("FAIL sl_dwe_pulse got %0h want 0", dwe); end
    checks++; if (m_load !== 1'b1) begin errors++; $display("FAIL sl_m_load got %0h want 1", m_load); end
    checks++; if (m_rd !== 3'd2) begin errors++; $display("FAIL sl_m_rd got %0h want 2", m_rd); end
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL sl_store_wb got v=%0h rw=%0h want v=1 rw=0", wb_valid, wb_reg_write); end
    checks++; if (mem[5] !== 16'h1234) begin errors++; $display("FAIL sl_mem5 got %0h want 1234", mem[5]); end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 3'd2) begin
      errors++; $display("FAIL sl_load_wb got v=%0h rw=%0h rd=%0h want 1 1 2", wb_valid, wb_reg_write, wb_rd); end
    checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL sl_wb_data got %0h want 1234", wb_data); end
    tick();
  endtask

  task automatic test_alu_fwd();
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'h00AA, 16'h0000);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    #1;
    checks++; if (m_fwd_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid got %0h want 1", m_fwd_valid); end
    checks++; if (m_fwd_data !== 16'h00AA) begin errors++; $display("FAIL fwd_data got %0h want 00aa", m_fwd_data); end
    checks++; if (m_load !== 1'b0 || dwe !== 1'b0) begin
      errors++; $display("FAIL fwd_ctrl got load=%0h dwe=%0h want 0 0", m_load, dwe); end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 3'd3) begin
      errors++; $display("FAIL fwd_wb got v=%0h rw=%0h rd=%0h want 1 1 3", wb_valid, wb_reg_write, wb_rd); end
    checks++; if (wb_data !== 16'h00AA) begin errors++; $display("FAIL fwd_wb_data got %0h want 00aa", wb_data); end
    checks++; if (m_fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_after got %0h want 0", m_fwd_valid); end
  endtask

  task automatic test_back_to_back();
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0101, 16'h0000);
    tick();
    set_ex(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 16'h0020, 16'h1111);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    #1;
    checks++; if (wb_rd !== 3'd1 || wb_data !== 16'h0101) begin
      errors++; $display("FAIL b2b_first got rd=%0h data=%0h want 1 0101", wb_rd, wb_data); end
    checks++; if (dwe !== 1'b1 || m_load !== 1'b1 || m_fwd_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_rw_m got dwe=%0h load=%0h fwd=%0h want 1 1 0", dwe, m_load, m_fwd_valid); end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 3'd5 || wb_data !== 16'h0020) begin
      errors++; $display("FAIL b2b_rw_wb got v=%0h rd=%0h data=%0h want 1 5 0020", wb_valid, wb_rd, wb_data); end
    checks++; if (mem[32] !== 16'h1111) begin errors++; $display("FAIL b2b_mem32 got %0h want 1111", mem[32]); end
    tick();
  endtask

  task automatic test_stall();
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0007, 16'h5A5A);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    tick(); tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 16'h0007, 16'h0000);
    tick();
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 16'h0077, 16'h0000);
    stall = 1'b1;
    #1;
    checks++; if (addr !== 8'h07 || dwe !== 1'b0) begin
      errors++; $display("FAIL stall1_port got addr=%0h dwe=%0h want 07 0", addr, dwe); end
    tick();
    flush = 1'b1;
    #1;
    checks++; if (wb_valid !== 1'b0 || addr !== 8'h07 || m_load !== 1'b1) begin
      errors++; $display("FAIL stall1_hold got v=%0h addr=%0h load=%0h want 0 07 1", wb_valid, addr, m_load); end
    tick();
    checks++; if (wb_valid !== 1'b0 || addr !== 8'h07 || m_rd !== 3'd4) begin
      errors++; $display("FAIL stall2_hold got v=%0h addr=%0h rd=%0h want 0 07 4", wb_valid, addr, m_rd); end
    stall = 1'b0; flush = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 3'd4 || wb_data !== 16'h5A5A) begin
      errors++; $display("FAIL stall_release got v=%0h rd=%0h data=%0h want 1 4 5a5a", wb_valid, wb_rd, wb_data); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_pulse got %0h want 0", wb_valid); end
  endtask

  task automatic test_flush();
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0009, 16'hBEEF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    #1;
    checks++; if (dwe !== 1'b0 || m_load !== 1'b0) begin
      errors++; $display("FAIL flush_m got dwe=%0h load=%0h want 0 0", dwe, m_load); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb got %0h want 0", wb_valid); end
    checks++; if (mem[9] !== 16'h0000) begin errors++; $display("FAIL flush_mem9 got %0h want 0", mem[9]); end
  endtask

  task automatic test_reset_mid();
    set_ex(1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 16'h000C, 16'hCAFE);
    tick();
    rst = 1'b1;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    #1;
    checks++; if (dwe !== 1'b0) begin errors++; $display("FAIL rmid_dwe got %0h want 0", dwe); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (mem[12] !== 16'h0000) begin errors++; $display("FAIL rmid_mem12 got %0h want 0", mem[12]); end
    checks++; if (addr !== 8'h00 || wdata !== 16'h0000 || dwe !== 1'b0) begin
      errors++; $display("FAIL rmid_port got addr=%0h wdata=%0h dwe=%0h want 0 0 0", addr, wdata, dwe); end
    checks++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || m_load !== 1'b0 || m_fwd_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_ctrl got v=%0h rw=%0h load=%0h fwd=%0h want 0 0 0 0",
                         wb_valid, wb_reg_write, m_load, m_fwd_valid); end
  endtask

  task automatic test_addr_range();
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0105, 16'h7777);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    #1;
`ifdef MEM_ADDR_CHECK_EN
    checks++; if (dwe !== 1'b0) begin errors++; $display("FAIL rng_dwe got %0h want 0", dwe); end
    tick();
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL rng_fault got %0h want 1", mem_fault); end
    checks++; if (mem[5] !== 16'h1234) begin errors++; $display("FAIL rng_mem5 got %0h want 1234", mem[5]); end
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0105, 16'h0000);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h0000) begin
      errors++; $display("FAIL rng_load got v=%0h data=%0h want 1 0000", wb_valid, wb_data); end
    tick(); tick();
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL rng_sticky got %0h want 1", mem_fault); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL rng_clear got %0h want 0", mem_fault); end
`else
    checks++; if (dwe !== 1'b1 || addr !== 8'h05) begin
      errors++; $display("FAIL rng_dwe got dwe=%0h addr=%0h want 1 05", dwe, addr); end
    tick();
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL rng_fault got %0h want 0", mem_fault); end
    checks++; if (mem[5] !== 16'h7777) begin errors++; $display("FAIL rng_mem5 got %0h want 7777", mem[5]); end
`endif
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_alu_fwd();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_addr_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
